// File: rtl/btn_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning blocks: debounce FSM
// state encoding, a constant clog2 helper and the default 50 MHz timing.
// ----------------------------------------------------------------------------
package btn_pkg;

    // Debounce FSM state encoding (two stable states, two wait states)
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Reference clock the default timing constants are derived from
    localparam int unsigned CLK_FREQ_HZ           = 32'd50000000;

    // 20 ms of stability at 50 MHz before a new level is accepted
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 32'd1000000;

    // 1 s of hold at 50 MHz before a long press is reported
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 32'd50000000;

    // Upper bound (exclusive) for the debounce interval
    localparam int unsigned MAX_DEBOUNCE_CYCLES   = 32'd16777216;

    // Smallest width able to hold 'value' distinct codes (minimum 1 bit).
    // Bounded loop so it stays usable as a constant function everywhere.
    function automatic int unsigned btn_clog2(input int unsigned value);
        int unsigned width;
        width = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < {32'd0, value}) begin
                width = i + 1;
            end
        end
        if (width == 32'd0) begin
            width = 32'd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input. The reset value is a
// parameter so the idle level of the pin can be preloaded and no false edge
// is seen when reset releases. Generic: reused for other board inputs.
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input into the i_clk domain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// Conditions one raw mechanical push-button for the LED blink counter:
// 2-flop synchroniser, stability counter and a 4-state FSM produce a clean
// level (1 = pressed) plus one-cycle press / release strobes. All outputs
// are registered.
//
// Optional build macro: LONG_PRESS_EN
//   defined   : BTN_LONG pulses once per press after LONG_PRESS_CYCLES of hold
//   undefined : no long-press logic, BTN_LONG is tied to 0
// ----------------------------------------------------------------------------
module button_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b0
) (
    input  logic CLOCK_IN,
    input  logic RESET,
    input  logic BTN_IN,
    output logic BTN_LEVEL,
    output logic BTN_PRESS,
    output logic BTN_RELEASE,
    output logic BTN_LONG
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int unsigned CNT_W = btn_clog2(DEBOUNCE_CYCLES + 32'd1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    // An out-of-range configuration never accepts a level change, so a bad
    // parameter set fails safe (outputs stay released) instead of chattering.
    localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 32'd2) &&
                               (DEBOUNCE_CYCLES < MAX_DEBOUNCE_CYCLES) &&
                               (LONG_PRESS_CYCLES >= 32'd1);

    // ------------------------------------------------------------------
    // Synchroniser and polarity normalisation
    // ------------------------------------------------------------------
    logic w_sync_raw;
    logic w_s;

    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .i_clk (CLOCK_IN),
        .i_rst (RESET),
        .i_d   (BTN_IN),
        .o_q   (w_sync_raw)
    );

    // Normalised input: 1 = pressed regardless of board wiring
    assign w_s = w_sync_raw ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // FSM state and debounce counter
    // ------------------------------------------------------------------
    btn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic w_press_accept;
    logic w_release_accept;

    // Stability reached on this edge: the wait state has seen the new level
    // for DEBOUNCE_CYCLES consecutive samples including the current one.
    assign w_press_accept   = (r_state == PRESS_WAIT)   &&  w_s &&
                              (r_cnt == CNT_LAST) && PARAMS_OK;
    assign w_release_accept = (r_state == RELEASE_WAIT) && !w_s &&
                              (r_cnt == CNT_LAST) && PARAMS_OK;

    // Debounce FSM: stable/wait tracking, stability count, registered level and strobes
    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_level <= 1'b0;
                    if (w_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s) begin
                        // Bounce: drop back silently
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_press_accept) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else if (r_cnt != CNT_FULL) begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end else begin
                        r_cnt   <= r_cnt;
                    end
                end
                PRESSED: begin
                    r_level <= 1'b1;
                    if (!w_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_s) begin
                        // Release bounce: level stays asserted
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (w_release_accept) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else if (r_cnt != CNT_FULL) begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end else begin
                        r_cnt   <= r_cnt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign BTN_LEVEL   = r_level;
    assign BTN_PRESS   = r_press;
    assign BTN_RELEASE = r_release;

`ifdef LONG_PRESS_EN
    // ------------------------------------------------------------------
    // Long-press detector
    // ------------------------------------------------------------------
    localparam int unsigned LONG_W = btn_clog2(LONG_PRESS_CYCLES + 32'd1);

    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(32'd1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_PRESS_CYCLES);
    localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_PRESS_CYCLES - 32'd1);

    logic [LONG_W-1:0] r_long_cnt;
    logic              r_long;

    // Hold-time counter: restarts on a newly accepted press only, so a release
    // bounce back into PRESSED cannot re-arm it and at most one pulse per press
    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else if (w_press_accept) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else if ((r_state == PRESSED) || (r_state == RELEASE_WAIT)) begin
            if (w_release_accept) begin
                r_long_cnt <= '0;
                r_long     <= 1'b0;
            end else if (r_long_cnt != LONG_LAST) begin
                r_long_cnt <= r_long_cnt + LONG_ONE;
                r_long     <= (r_long_cnt == LONG_PRE);
            end else begin
                r_long_cnt <= r_long_cnt;
                r_long     <= 1'b0;
            end
        end else begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end
    end

    assign BTN_LONG = r_long;
`else
    assign BTN_LONG = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// ----------------------------------------------------------------------------
// tb_button_debounce
// Table of input segments {level, length, expected strobe}; each expected
// strobe is scheduled on a scoreboard queue at the edge that first samples
// the segment (event edge = start + DEBOUNCE_CYCLES + 1) and checked when
// the DUT outputs are sampled on the falling edge. Reset corner cases are
// hand-written sequences.
// ----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int DEB   = 8;
    localparam int LONGC = 32;

    logic CLOCK_IN = 1'b0;
    logic RESET    = 1'b0;
    logic BTN_IN   = 1'b0;
    logic BTN_LEVEL;
    logic BTN_PRESS;
    logic BTN_RELEASE;
    logic BTN_LONG;

    button_debounce #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONGC),
        .ACTIVE_LOW        (1'b0)
    ) dut (
        .CLOCK_IN    (CLOCK_IN),
        .RESET       (RESET),
        .BTN_IN      (BTN_IN),
        .BTN_LEVEL   (BTN_LEVEL),
        .BTN_PRESS   (BTN_PRESS),
        .BTN_RELEASE (BTN_RELEASE),
        .BTN_LONG    (BTN_LONG)
    );

    always #5 CLOCK_IN = ~CLOCK_IN;

    typedef enum int {EV_NONE, EV_PRESS, EV_RELEASE, EV_LONG} ev_e;

    typedef struct {
        int  cyc;
        ev_e kind;
    } exp_t;

    typedef struct {
        logic lvl;
        int   len;
        ev_e  ev;
        bit   long_ev;
    } seg_t;

    exp_t sb[$];
    seg_t tbl[$];

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic exp_level = 1'b0;

    task automatic chk(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %b, want %b", name, cyc, act, req);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_level"},   BTN_LEVEL,   1'b0);
        chk({name, "_press"},   BTN_PRESS,   1'b0);
        chk({name, "_release"}, BTN_RELEASE, 1'b0);
        chk({name, "_long"},    BTN_LONG,    1'b0);
    endtask

    task automatic expect_ev(input ev_e kind, input int at);
        exp_t e;
        e.cyc  = at;
        e.kind = kind;
        sb.push_back(e);
    endtask

    // Compare outputs of the current cycle against the scoreboard
    task automatic check_outputs();
        logic ep;
        logic er;
        logic el;
        exp_t e;
        ep = 1'b0;
        er = 1'b0;
        el = 1'b0;
        while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
            e = sb.pop_front();
            if (e.cyc == cyc) begin
                if (e.kind == EV_PRESS)   ep = 1'b1;
                if (e.kind == EV_RELEASE) er = 1'b1;
                if (e.kind == EV_LONG)    el = 1'b1;
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event @edge %0d: event kind %0d due at edge %0d", cyc, e.kind, e.cyc);
            end
        end
        if (ep) exp_level = 1'b1;
        if (er) exp_level = 1'b0;
        chk("press",   BTN_PRESS,   ep);
        chk("release", BTN_RELEASE, er);
        chk("long",    BTN_LONG,    el);
        chk("level",   BTN_LEVEL,   exp_level);
    endtask

    // One clock: drive, let the edge sample it, check on the falling edge
    task automatic step(input logic b);
        BTN_IN = b;
        @(posedge CLOCK_IN);
        cyc++;
        @(negedge CLOCK_IN);
        check_outputs();
    endtask

    function automatic seg_t mk(input logic l, input int n, input ev_e e, input bit lg);
        seg_t s;
        s.lvl     = l;
        s.len     = n;
        s.ev      = e;
        s.long_ev = lg;
        return s;
    endfunction

    initial begin
        int k;

        // ---- stimulus table ----
        tbl.push_back(mk(1'b0, 20, EV_RELEASE, 1'b0));       // clean release
        for (int i = 0; i < 5; i++) begin                    // press bounce
            tbl.push_back(mk(1'b1, 3, EV_NONE, 1'b0));
            tbl.push_back(mk(1'b0, 3, EV_NONE, 1'b0));
        end
        tbl.push_back(mk(1'b1, 20, EV_PRESS, 1'b0));         // settles pressed
        tbl.push_back(mk(1'b0, 2,  EV_NONE, 1'b0));          // release glitches
        tbl.push_back(mk(1'b1, 3,  EV_NONE, 1'b0));
        tbl.push_back(mk(1'b0, 2,  EV_NONE, 1'b0));
        tbl.push_back(mk(1'b1, 3,  EV_NONE, 1'b0));
        tbl.push_back(mk(1'b0, 20, EV_RELEASE, 1'b0));       // settles released
        for (int i = 0; i < 10; i++) begin                   // toggle every cycle
            tbl.push_back(mk(1'b1, 1, EV_NONE, 1'b0));
            tbl.push_back(mk(1'b0, 1, EV_NONE, 1'b0));
        end
        tbl.push_back(mk(1'b0, 10, EV_NONE, 1'b0));
        tbl.push_back(mk(1'b1, 8,  EV_PRESS, 1'b0));         // exactly DEB long
        tbl.push_back(mk(1'b0, 7,  EV_NONE, 1'b0));          // one short
        tbl.push_back(mk(1'b1, 10, EV_NONE, 1'b0));
        tbl.push_back(mk(1'b0, 8,  EV_RELEASE, 1'b0));       // exactly DEB long
        tbl.push_back(mk(1'b1, 7,  EV_NONE, 1'b0));          // one short
        tbl.push_back(mk(1'b0, 12, EV_NONE, 1'b0));
        tbl.push_back(mk(1'b1, 50, EV_PRESS, 1'b1));         // long hold
        tbl.push_back(mk(1'b0, 20, EV_RELEASE, 1'b0));

        // ---- reset with button held ----
        BTN_IN = 1'b1;
        #1 RESET = 1'b1;
        #1 chk_all_zero("async_reset");
        repeat (3) step(1'b1);
        RESET = 1'b0;
        k = cyc + 1;
        expect_ev(EV_PRESS, k + DEB + 1);
        repeat (20) step(1'b1);

        // ---- table-driven segments ----
        foreach (tbl[i]) begin
            k = cyc + 1;
            if (tbl[i].ev != EV_NONE) expect_ev(tbl[i].ev, k + DEB + 1);
`ifdef LONG_PRESS_EN
            if (tbl[i].long_ev) expect_ev(EV_LONG, k + DEB + 1 + LONGC);
`endif
            repeat (tbl[i].len) step(tbl[i].lvl);
        end

        // ---- reset in the middle of the press debounce ----
        repeat (7) step(1'b1);
        #1 RESET = 1'b1;
        #1 chk_all_zero("reset_mid_debounce");
        repeat (2) step(1'b1);
        RESET = 1'b0;
        k = cyc + 1;
        expect_ev(EV_PRESS, k + DEB + 1);
        repeat (20) step(1'b1);

        // ---- reset while pressed: level drops at once, no release strobe ----
        #1 RESET = 1'b1;
        #1 chk_all_zero("reset_pressed");
        exp_level = 1'b0;
        repeat (2) step(1'b0);
        RESET = 1'b0;
        repeat (15) step(1'b0);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d outstanding, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
